// File: rtl/sd_arbiter.sv
// sd_arbiter: round-robin sharing of the mist_io SD block port between two disk clients,
// with sd_ack synchronisation and a request timeout.
module sd_arbiter #(
  parameter int TIMEOUT = 50000000,
  parameter int TO_W    = 26
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] c0_lba,
  input  logic        c0_rd,
  input  logic        c0_wr,
  output logic        c0_ack,
  output logic        c0_err,
  output logic        c0_buff_wr,
  input  logic [7:0]  c0_buff_din,
  input  logic [31:0] c1_lba,
  input  logic        c1_rd,
  input  logic        c1_wr,
  output logic        c1_ack,
  output logic        c1_err,
  output logic        c1_buff_wr,
  input  logic [7:0]  c1_buff_din,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic        grant
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
  state_t          state_q, state_d;
  logic            ack_m_q, ack_s_q;
  logic            grant_q, grant_d;
  logic [31:0]     lba_q, lba_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [1:0]      err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            p0, p1, win, timeout;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack_m_q <= 1'b0;
      ack_s_q <= 1'b0;
      grant_q <= 1'b0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_m_q <= sd_ack;
      ack_s_q <= ack_m_q;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Round-robin uses the registered grant, so simultaneous requests favour the other client.
  always_comb begin
    p0      = c0_rd | c0_wr;
    p1      = c1_rd | c1_wr;
    win     = (p0 & p1) ? ~grant_q : p1;
    timeout = (TIMEOUT != 0) && (cnt_q == LAST);
    state_d = state_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!ack_s_q && (p0 | p1)) begin
        state_d = REQ;
        grant_d = win;
        lba_d   = win ? c1_lba : c0_lba;
        rd_d    = win ? c1_rd : c0_rd;
        wr_d    = win ? (c1_wr & ~c1_rd) : (c0_wr & ~c0_rd);
        cnt_d   = '0;
      end
      REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (ack_s_q) begin
          state_d = XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (timeout) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = grant_q ? 2'b10 : 2'b01;
        end
      end
      XFER: if (!ack_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Buffer strobes are gated by state so late strobes after a timeout are dropped.
  always_comb begin
    busy        = state_q != IDLE;
    grant       = grant_q;
    sd_lba      = lba_q;
    sd_rd       = rd_q;
    sd_wr       = wr_q;
    c0_ack      = (state_q == XFER) && !grant_q;
    c1_ack      = (state_q == XFER) && grant_q;
    c0_err      = err_q[0];
    c1_err      = err_q[1];
    c0_buff_wr  = sd_buff_wr && busy && !grant_q;
    c1_buff_wr  = sd_buff_wr && busy && grant_q;
    sd_buff_din = grant_q ? c1_buff_din : c0_buff_din;
  end
endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter: table-driven grant/handshake vectors plus timeout and reset sequences.
module tb_sd_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] c0_lba, c1_lba, sd_lba;
  logic        c0_rd, c0_wr, c0_ack, c0_err, c0_buff_wr;
  logic        c1_rd, c1_wr, c1_ack, c1_err, c1_buff_wr;
  logic [7:0]  c0_buff_din, c1_buff_din, sd_buff_din;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, grant;
  int checks = 0;
  int errors = 0;

  sd_arbiter #(.TIMEOUT(100), .TO_W(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .c0_lba(c0_lba), .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_ack(c0_ack), .c0_err(c0_err),
    .c0_buff_wr(c0_buff_wr), .c0_buff_din(c0_buff_din),
    .c1_lba(c1_lba), .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_ack(c1_ack), .c1_err(c1_err),
    .c1_buff_wr(c1_buff_wr), .c1_buff_din(c1_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .busy(busy), .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        c0r, c0w, c1r, c1w;
    logic [31:0] l0, l1;
    logic        eg, erd, ewr;
    logic [31:0] elba;
  } vec_t;

  vec_t v[9];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    int n0, n1, np;
    v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00001234, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 32'h00001234};
    v[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00001111, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 32'hCAFE0001};
    v[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00002222, 32'hCAFE0002, 1'b0, 1'b1, 1'b0, 32'h00002222};
    v[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00003333, 32'hCAFE0003, 1'b1, 1'b0, 1'b1, 32'hCAFE0003};
    v[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00004444, 32'hCAFE0004, 1'b0, 1'b1, 1'b0, 32'h00004444};
    v[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00005555, 32'hCAFE0005, 1'b0, 1'b1, 1'b0, 32'h00005555};
    v[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00006666, 32'hCAFE0006, 1'b1, 1'b0, 1'b1, 32'hCAFE0006};
    v[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00007777, 32'hCAFE0007, 1'b1, 1'b1, 1'b0, 32'hCAFE0007};
    v[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00008888, 32'hCAFE0008, 1'b0, 1'b0, 1'b1, 32'h00008888};
    reset_n = 1'b0;
    {c0_rd, c0_wr, c1_rd, c1_wr, sd_ack, sd_buff_wr} = '0;
    c0_lba = '0; c1_lba = '0; c0_buff_din = '0; c1_buff_din = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {c0_ack, c1_ack, c0_err, c1_err}, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      c0_lba = v[i].l0;
      c1_lba = v[i].l1;
      {c0_rd, c0_wr, c1_rd, c1_wr} = {v[i].c0r, v[i].c0w, v[i].c1r, v[i].c1w};
      tick();
      chk("grant", grant, v[i].eg);
      chk("busy_on", busy, 1);
      chk("sd_rd", sd_rd, v[i].erd);
      chk("sd_wr", sd_wr, v[i].ewr);
      chk("sd_lba", sd_lba, v[i].elba);
      {c0_rd, c0_wr, c1_rd, c1_wr} = '0;
      c0_lba = 32'hFFFF0000;
      c1_lba = 32'h0000FFFF;
      repeat (10) tick();
      chk("rd_held", {sd_rd, sd_wr}, {v[i].erd, v[i].ewr});
      chk("lba_held", sd_lba, v[i].elba);
      sd_ack = 1'b1;
      repeat (2) tick();
      chk("ack_early", v[i].eg ? c1_ack : c0_ack, 0);
      tick();
      chk("ack_rise", v[i].eg ? c1_ack : c0_ack, 1);
      chk("ack_other", v[i].eg ? c0_ack : c1_ack, 0);
      chk("req_clr", {sd_rd, sd_wr}, 0);
      c0_buff_din = 8'h5A;
      c1_buff_din = 8'hA5;
      #1;
      chk("buff_din", sd_buff_din, v[i].eg ? 8'hA5 : 8'h5A);
      n0 = 0; n1 = 0;
      np = (i == 0) ? 512 : 3;
      for (int k = 0; k < np; k++) begin
        sd_buff_wr = 1'b1;
        #1;
        n0 += int'(c0_buff_wr);
        n1 += int'(c1_buff_wr);
        sd_buff_wr = 1'b0;
        #1;
      end
      chk("buf_granted", v[i].eg ? n1 : n0, np);
      chk("buf_other", v[i].eg ? n0 : n1, 0);
      tick();
      sd_ack = 1'b0;
      repeat (2) tick();
      chk("ack_hold", v[i].eg ? c1_ack : c0_ack, 1);
      tick();
      chk("ack_fall", v[i].eg ? c1_ack : c0_ack, 0);
      chk("busy_off", busy, 0);
    end
    // Timeout: 100 cycles in REQ without sd_ack.
    c0_rd = 1'b1;
    c0_lba = 32'h00000055;
    tick();
    chk("to_grant", {grant, sd_rd}, 2'b01);
    c0_rd = 1'b0;
    repeat (99) tick();
    chk("to_pre_rd", sd_rd, 1);
    chk("to_pre_err", c0_err, 0);
    tick();
    chk("to_rd_drop", sd_rd, 0);
    chk("to_err", {c1_err, c0_err}, 2'b01);
    chk("to_busy", busy, 0);
    tick();
    chk("to_err_pulse", c0_err, 0);
    // Late sd_ack: no ack to the client, and no grant while ack_s is high.
    sd_ack = 1'b1;
    repeat (2) tick();
    c1_rd = 1'b1;
    repeat (5) tick();
    chk("late_busy", busy, 0);
    chk("late_ack", {c0_ack, c1_ack, sd_rd}, 0);
    sd_buff_wr = 1'b1;
    #1;
    chk("late_strobe", {c0_buff_wr, c1_buff_wr}, 0);
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    repeat (2) tick();
    chk("late_block", busy, 0);
    tick();
    chk("late_grant", {busy, grant, sd_rd}, 3'b111);
    c1_rd = 1'b0;
    // Reset in the middle of a client-1 transfer.
    sd_ack = 1'b1;
    repeat (3) tick();
    chk("pre_rst_ack", c1_ack, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_c1_ack", c1_ack, 0);
    chk("rst_mid_out", {sd_rd, sd_wr, busy, grant}, 0);
    chk("rst_mid_lba", sd_lba, 0);
    sd_ack = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    c0_rd = 1'b1;
    c0_lba = 32'h00000077;
    tick();
    chk("post_rst_grant", {busy, grant, sd_rd}, 3'b101);
    chk("post_rst_lba", sd_lba, 32'h00000077);
    c0_rd = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_arbiter.md
Name: sd_arbiter

Overview:
- Shares the single SD block-level port of the MiST I/O controller (sd_lba/sd_rd/sd_wr/sd_ack plus sector buffer) between two disk clients, e.g. TR-DOS/Beta disk and DivMMC.
- Round-robin arbitration; each client sees a private copy of the mist_io SD interface with unchanged handshake semantics.
- Synchronises sd_ack into clk_sys.
- Enforces a request timeout, so a client whose request the ARM never serves cannot lock the port.

Parameters:
TIMEOUT, 50000000, clk_sys cycles to wait for sd_ack after issuing a request; 0 disables the timeout.
TO_W, 26, width of the timeout counter; must hold TIMEOUT.

Ports:
clk_sys  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
c0_lba  in  32  client 0 sector LBA
c0_rd  in  1  client 0 read request (level)
c0_wr  in  1  client 0 write request (level)
c0_ack  out  1  client 0 transfer acknowledge
c0_err  out  1  client 0 one-cycle timeout pulse
c0_buff_wr  out  1  client 0 sector-buffer write strobe
c0_buff_din  in  8  client 0 buffer read data (sector data to ARM)
c1_lba, c1_rd, c1_wr, c1_ack, c1_err, c1_buff_wr, c1_buff_din  same directions, widths and meanings for client 1
sd_lba  out  32  to mist_io sd_lba
sd_rd  out  1  to mist_io sd_rd
sd_wr  out  1  to mist_io sd_wr
sd_ack  in  1  from mist_io; SPI-clock domain, asynchronous
sd_buff_wr  in  1  from mist_io buffer write strobe; already in clk_sys
sd_buff_din  out  8  to mist_io sd_buff_din
busy  out  1  arbiter not IDLE
grant  out  1  index of the current or last granted client

Behaviour:
- Clock and reset: one clock, clk_sys; reset is asynchronous and active-low on reset_n.
- Reset values:
  - sd_rd, sd_wr, sd_lba, c0_ack, c1_ack, c0_err, c1_err, busy, grant are all 0.
  - The FSM is in IDLE; the sync flops and the timeout counter are 0.
- sd_ack synchronisation: 2-flop synchroniser to ack_s. All FSM decisions use ack_s only.
- FSM states:
  - IDLE:
    - Requires ack_s=0; otherwise stays in IDLE.
    - Client N is pending when cN_rd|cN_wr.
    - If both clients are pending, the client opposite to grant wins (round-robin). If one is pending, it wins.
    - On the granting edge, the arbiter registers:
      - grant;
      - sd_lba = cN_lba;
      - sd_rd = cN_rd;
      - sd_wr = cN_wr & ~cN_rd (read wins when both are set);
      - busy=1; timeout counter cleared.
    - Next state is REQ.
  - REQ:
    - sd_rd/sd_wr and sd_lba are held; the counter increments.
    - ack_s=1: clear sd_rd and sd_wr, set cN_ack=1, go to XFER.
    - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: clear sd_rd/sd_wr, pulse cN_err for 1 cycle, go to IDLE.
    - Client deasserting its request in REQ is ignored; the request is committed.
  - XFER:
    - cN_ack stays 1 while ack_s=1.
    - ack_s=0: clear cN_ack, busy=0, go to IDLE.
    - No timeout in XFER.
- Latency:
  - Request sampled in IDLE to sd_rd/sd_wr high: 1 edge.
  - sd_ack rise to cN_ack rise: 3 edges.
  - sd_ack fall to cN_ack fall: 3 edges.
  - Earliest next grant: the edge after returning to IDLE.
- Buffer routing (combinational):
  - cN_buff_wr = sd_buff_wr & (state in REQ or XFER) & (grant==N).
  - The non-granted client's strobe is always 0.
  - sd_buff_din = grant ? c1_buff_din : c0_buff_din.
  - sd_buff_addr and sd_buff_dout are not routed by this block; they are broadcast from mist_io to both clients.
- sd_lba is stable from grant until the next grant.
- Boundary cases:
  - Timeout followed by a late sd_ack: IDLE blocks new grants until ack_s=0. Late buffer strobes are dropped (gated by state).
  - Asynchronous reset mid-REQ or mid-XFER: all outputs drop to reset values immediately; no pending state survives.
  - Both clients request on the same edge that grant updates: round-robin uses the registered grant value.

Test Plan:
- Single read: c0_rd=1, c0_lba=0x00001234. Expect sd_rd=1 and sd_lba=0x1234 one edge later. Model raises sd_ack after 10 cycles: sd_rd=0 and c0_ack=1 three edges after the rise. 512 sd_buff_wr pulses all reach c0_buff_wr, none reach c1_buff_wr. sd_ack low: c0_ack=0 after 3 edges and busy=0.
- Contention: c0_rd and c1_wr both asserted from reset (grant=0). Client 1 is served first with sd_wr=1 and sd_lba=c1_lba; client 0 second. Repeat with both held: grants alternate 1,0,1,0.
- Write data path: with client 1 granted in XFER, drive c1_buff_din=0xA5 and c0_buff_din=0x5A. Expect sd_buff_din=0xA5.
- Rd and wr both set: c0_rd=c0_wr=1. Expect sd_rd=1 and sd_wr=0.
- Timeout with TIMEOUT=100 and no sd_ack: sd_rd drops and c0_err pulses exactly 1 cycle after 100 cycles in REQ. A late sd_ack pulse then produces no c0_ack, and no new grant happens until ack_s=0.
- Reset mid-XFER: assert reset_n=0 while c1_ack=1. Expect c1_ack, sd_rd, sd_wr, busy and grant at 0 immediately. After release with sd_ack low, the arbiter is IDLE and accepts a new request.
